// File: rtl/wasm_pkg.sv
// Shared WASM core types: FPU opcodes, trap codes and the FPU issue FSM states,
// plus small opcode-classification helpers.
package wasm_pkg;

    typedef enum logic [4:0] {
        FPU_ADD      = 5'd0,
        FPU_SUB      = 5'd1,
        FPU_MUL      = 5'd2,
        FPU_DIV      = 5'd3,
        FPU_MIN      = 5'd4,
        FPU_MAX      = 5'd5,
        FPU_COPYSIGN = 5'd6,
        FPU_ABS      = 5'd7,
        FPU_NEG      = 5'd8,
        FPU_CEIL     = 5'd9,
        FPU_FLOOR    = 5'd10,
        FPU_TRUNC    = 5'd11,
        FPU_NEAREST  = 5'd12,
        FPU_SQRT     = 5'd13,
        FPU_EQ       = 5'd14,
        FPU_NE       = 5'd15,
        FPU_LT       = 5'd16,
        FPU_GT       = 5'd17,
        FPU_LE       = 5'd18,
        FPU_GE       = 5'd19
    } fpu_op_t;

    typedef enum logic [2:0] {
        TRAP_NONE         = 3'd0,
        TRAP_UNREACHABLE  = 3'd1,
        TRAP_INT_OVERFLOW = 3'd2,
        TRAP_INT_DIV_ZERO = 3'd3,
        TRAP_INVALID_CONV = 3'd4,
        TRAP_FPU_TIMEOUT  = 3'd5
    } trap_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } fpu_issue_state_t;

    function automatic logic fpu_is_unary(input fpu_op_t op);
        case (op)
            FPU_ABS, FPU_NEG, FPU_CEIL, FPU_FLOOR,
            FPU_TRUNC, FPU_NEAREST, FPU_SQRT: fpu_is_unary = 1'b1;
            default:                          fpu_is_unary = 1'b0;
        endcase
    endfunction

    function automatic logic fpu_is_cmp(input fpu_op_t op);
        case (op)
            FPU_EQ, FPU_NE, FPU_LT, FPU_GT, FPU_LE, FPU_GE: fpu_is_cmp = 1'b1;
            default:                                        fpu_is_cmp = 1'b0;
        endcase
    endfunction

    function automatic logic fpu_is_nan64(input logic [63:0] v);
        fpu_is_nan64 = (&v[62:52]) && (|v[51:0]);
    endfunction

endpackage

// File: rtl/wasm_fpu_issue.sv
// FPU request initiator: one registered issue beat per request, watchdog on the FPU reply.
// Optional statistics counters are built when WASM_FPU_ISSUE_STATS_EN is defined.
module wasm_fpu_issue
    import wasm_pkg::*;
#(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  fpu_op_t          req_op,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             fpu_valid_in,
    output fpu_op_t          fpu_op,
    output logic [63:0]      fpu_a,
    output logic [63:0]      fpu_b,
    input  logic             fpu_valid_out,
    input  logic [63:0]      fpu_result,
    input  trap_t            fpu_trap,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic             rsp_is_i32,
    output logic [TAG_W-1:0] rsp_tag,
    output trap_t            rsp_trap,
    output logic             busy,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_nan,
    output logic [31:0]      stat_stall
);

    localparam int              WD_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic            WD_EN   = (TIMEOUT_CYCLES > 0);

    fpu_issue_state_t r_state;
    fpu_issue_state_t w_next;
    logic             w_capture;
    logic             w_timeout;
    fpu_op_t          r_fpu_op;
    logic [63:0]      r_fpu_a;
    logic [63:0]      r_fpu_b;
    logic [TAG_W-1:0] r_tag;
    logic [63:0]      r_rsp_data;
    trap_t            r_rsp_trap;
    logic [WD_W-1:0]  r_wd;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; the watchdog fires on the last permitted WAIT cycle
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) w_next = ISSUE;
                else           w_next = IDLE;
            end
            ISSUE: begin
                if (fpu_valid_out) begin
                    w_capture = 1'b1;
                    w_next    = RESP;
                end else begin
                    w_next    = WAIT;
                end
            end
            WAIT: begin
                if (fpu_valid_out) begin
                    w_capture = 1'b1;
                    w_next    = RESP;
                end else if (WD_EN && (r_wd == WD_LAST)) begin
                    w_timeout = 1'b1;
                    w_next    = RESP;
                end else begin
                    w_next    = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) w_next = IDLE;
                else           w_next = RESP;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latch, response capture and watchdog count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fpu_op   <= FPU_ADD;
            r_fpu_a    <= 64'd0;
            r_fpu_b    <= 64'd0;
            r_tag      <= '0;
            r_rsp_data <= 64'd0;
            r_rsp_trap <= TRAP_NONE;
            r_wd       <= '0;
        end else begin
            if ((r_state == IDLE) && req_valid) begin
                r_fpu_op <= req_op;
                r_fpu_a  <= req_a;
                r_fpu_b  <= fpu_is_unary(req_op) ? 64'd0 : req_b;
                r_tag    <= req_tag;
            end
            if (w_capture) begin
                r_rsp_data <= fpu_is_cmp(r_fpu_op) ? {63'd0, fpu_result[0]} : fpu_result;
                r_rsp_trap <= fpu_trap;
            end else if (w_timeout) begin
                r_rsp_data <= 64'd0;
                r_rsp_trap <= TRAP_FPU_TIMEOUT;
            end
            if (r_state == WAIT) r_wd <= r_wd + WD_W'(1);
            else                 r_wd <= '0;
        end
    end

    assign req_ready    = (r_state == IDLE);
    assign fpu_valid_in = (r_state == ISSUE);
    assign rsp_valid    = (r_state == RESP);
    assign busy         = (r_state != IDLE);
    assign fpu_op       = r_fpu_op;
    assign fpu_a        = r_fpu_a;
    assign fpu_b        = r_fpu_b;
    assign rsp_data     = r_rsp_data;
    assign rsp_trap     = r_rsp_trap;
    assign rsp_tag      = r_tag;
    assign rsp_is_i32   = fpu_is_cmp(r_fpu_op);

`ifdef WASM_FPU_ISSUE_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_nan;
    logic [31:0] r_stat_stall;

    // Saturating activity counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_issued <= 32'd0;
            r_stat_nan    <= 32'd0;
            r_stat_stall  <= 32'd0;
        end else begin
            if ((r_state == ISSUE) && (r_stat_issued != 32'hFFFF_FFFF))
                r_stat_issued <= r_stat_issued + 32'd1;
            if (w_capture && !fpu_is_cmp(r_fpu_op) && fpu_is_nan64(fpu_result)
                && (r_stat_nan != 32'hFFFF_FFFF))
                r_stat_nan <= r_stat_nan + 32'd1;
            if ((r_state == RESP) && !rsp_ready && (r_stat_stall != 32'hFFFF_FFFF))
                r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_nan    = r_stat_nan;
    assign stat_stall  = r_stat_stall;
`else
    assign stat_issued = 32'd0;
    assign stat_nan    = 32'd0;
    assign stat_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_wasm_fpu_issue.sv
// Directed bench for wasm_fpu_issue with a behavioural FPU model (combinational,
// 4-cycle delayed, or silent) and hand-computed expected values.
module tb_wasm_fpu_issue;
    import wasm_pkg::*;

    localparam logic [63:0] F1  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] F2  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] F3  = 64'h4008_0000_0000_0000;
    localparam logic [63:0] F6  = 64'h4018_0000_0000_0000;
    localparam logic [63:0] FM1 = 64'hBFF0_0000_0000_0000;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    fpu_op_t     req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_tag;
    logic        fpu_valid_in;
    fpu_op_t     fpu_op;
    logic [63:0] fpu_a;
    logic [63:0] fpu_b;
    logic        fpu_valid_out;
    logic [63:0] fpu_result;
    trap_t       fpu_trap;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_is_i32;
    logic [3:0]  rsp_tag;
    trap_t       rsp_trap;
    logic        busy;
    logic [31:0] stat_issued;
    logic [31:0] stat_nan;
    logic [31:0] stat_stall;

    int n_checks = 0;
    int n_fail   = 0;

    wasm_fpu_issue #(.TAG_W(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .fpu_valid_in(fpu_valid_in), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_valid_out(fpu_valid_out), .fpu_result(fpu_result), .fpu_trap(fpu_trap),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_is_i32(rsp_is_i32), .rsp_tag(rsp_tag), .rsp_trap(rsp_trap), .busy(busy),
        .stat_issued(stat_issued), .stat_nan(stat_nan), .stat_stall(stat_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FPU model: mode 0 combinational, 1 replies 4 cycles after issue, 2 never replies
    logic [1:0] mode = 2'd0;
    logic       spur = 1'b0;
    logic [3:0] r_dly = 4'd0;
    int         pulses = 0;

    always @(posedge clk) begin
        r_dly <= {r_dly[2:0], fpu_valid_in};
        if (fpu_valid_in) pulses <= pulses + 1;
    end

    function automatic logic [63:0] model_fpu(input fpu_op_t op, input logic [63:0] a, input logic [63:0] b);
        real ra;
        real rb;
        logic lt;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        lt = (ra < rb);
        case (op)
            FPU_ADD: model_fpu = $realtobits(ra + rb);
            FPU_SUB: model_fpu = $realtobits(ra - rb);
            FPU_MUL: model_fpu = $realtobits(ra * rb);
            FPU_DIV: model_fpu = (b[62:0] == 63'd0) ? QNAN : $realtobits(ra / rb);
            FPU_NEG: model_fpu = a ^ 64'h8000_0000_0000_0000;
            // upper bits deliberately NaN-shaped garbage: must be dropped by zero-extension
            FPU_LT:  model_fpu = {1'b0, 11'h7FF, 51'h1, lt};
            default: model_fpu = a;
        endcase
    endfunction

    assign fpu_valid_out = ((mode == 2'd0) && fpu_valid_in) || ((mode == 2'd1) && r_dly[3]) || spur;
    assign fpu_result    = spur ? 64'hDEAD_BEEF_0000_0001 : model_fpu(fpu_op, fpu_a, fpu_b);
    assign fpu_trap      = spur ? TRAP_UNREACHABLE :
                           ((fpu_op == FPU_DIV) && (fpu_b[62:0] == 63'd0)) ? TRAP_INT_DIV_ZERO : TRAP_NONE;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Present one request, then step until rsp_valid (bounded); lat counts edges from accept
    task automatic run(input fpu_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] tag, output int lat, output int held_bad);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        tick();
        req_valid = 1'b0;
        lat       = 1;
        held_bad  = 0;
        while (!rsp_valid && lat < 40) begin
            if ((fpu_a !== a) || (fpu_op !== op)) held_bad++;
            tick();
            lat++;
        end
        check("rsp_arrived", rsp_valid, 1'b1);
    endtask

    int lat;
    int hb;
    int p0;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = FPU_ADD; req_a = 64'd0; req_b = 64'd0;
        req_tag = 4'd0; rsp_ready = 1'b0;
        repeat (2) tick();
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_valid_in", fpu_valid_in, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_trap", rsp_trap, TRAP_NONE);
        check("rst_data", rsp_data, 64'd0);
        check("rst_stat_issued", stat_issued, 32'd0);
        rst = 1'b0;
        tick();

        // 1: ADD, latency 2 cycles from accept
        req_valid = 1'b1; req_op = FPU_ADD; req_a = F1; req_b = F2; req_tag = 4'd3;
        tick();
        req_valid = 1'b0;
        check("t1_issue_pulse", fpu_valid_in, 1'b1);
        check("t1_req_ready_low", req_ready, 1'b0);
        check("t1_no_rsp_yet", rsp_valid, 1'b0);
        tick();
        check("t1_rsp_valid", rsp_valid, 1'b1);
        check("t1_data", rsp_data, F3);
        check("t1_tag", rsp_tag, 4'd3);
        check("t1_is_i32", rsp_is_i32, 1'b0);
        check("t1_trap", rsp_trap, TRAP_NONE);
        check("t1_pulse_done", fpu_valid_in, 1'b0);
        ack();
        check("t1_idle_ready", req_ready, 1'b1);

        // 2: compare zero-extends bit0; unary op forces operand b to zero
        run(FPU_LT, F1, F2, 4'd5, lat, hb);
        check("t2_lt_data", rsp_data, 64'd1);
        check("t2_lt_is_i32", rsp_is_i32, 1'b1);
        check("t2_lt_tag", rsp_tag, 4'd5);
        ack();
        req_valid = 1'b1; req_op = FPU_NEG; req_a = F1; req_b = 64'hFFFF_FFFF_FFFF_FFFF; req_tag = 4'd6;
        tick();
        req_valid = 1'b0;
        check("t2_neg_issue", fpu_valid_in, 1'b1);
        check("t2_neg_fpu_b", fpu_b, 64'd0);
        check("t2_neg_fpu_a", fpu_a, F1);
        tick();
        check("t2_neg_data", rsp_data, FM1);
        check("t2_neg_is_i32", rsp_is_i32, 1'b0);
        ack();

        // 3: backpressure holds the response; next request waits until after handshake
        run(FPU_MUL, F2, F3, 4'd7, lat, hb);
        check("t3_latency", lat, 2);
        req_valid = 1'b1; req_op = FPU_ADD; req_a = F1; req_b = F1; req_tag = 4'd9;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", rsp_valid, 1'b1);
            check("t3_hold_data", rsp_data, F6);
            check("t3_hold_tag", rsp_tag, 4'd7);
            check("t3_hold_req_ready", req_ready, 1'b0);
            tick();
        end
        check("t3_hold_data_end", rsp_data, F6);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t3_after_hs_ready", req_ready, 1'b1);
        check("t3_after_hs_no_issue", fpu_valid_in, 1'b0);
        check("t3_after_hs_rsp", rsp_valid, 1'b0);
        tick();
        req_valid = 1'b0;
        check("t3_next_issue", fpu_valid_in, 1'b1);
        check("t3_next_fpu_a", fpu_a, F1);
        tick();
        check("t3_next_data", rsp_data, F2);
        check("t3_next_tag", rsp_tag, 4'd9);
        ack();

        // 4: silent FPU -> watchdog after 8 WAIT cycles; late pulses ignored
        mode = 2'd2;
        run(FPU_SUB, F2, F1, 4'hA, lat, hb);
        check("t4_latency", lat, 10);
        check("t4_held", hb, 0);
        check("t4_trap", rsp_trap, TRAP_FPU_TIMEOUT);
        check("t4_data", rsp_data, 64'd0);
        check("t4_tag", rsp_tag, 4'hA);
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("t4_late_data", rsp_data, 64'd0);
        check("t4_late_trap", rsp_trap, TRAP_FPU_TIMEOUT);
        check("t4_late_valid", rsp_valid, 1'b1);
        ack();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("t4_idle_spur_rsp", rsp_valid, 1'b0);
        check("t4_idle_spur_busy", busy, 1'b0);

        // 5: multi-cycle FPU (reply 4 cycles after issue)
        mode = 2'd1;
        p0 = pulses;
        run(FPU_MUL, F2, F3, 4'd2, lat, hb);
        check("t5_latency", lat, 6);
        check("t5_held", hb, 0);
        check("t5_fpu_b_held", fpu_b, F3);
        check("t5_data", rsp_data, F6);
        check("t5_single_pulse", pulses - p0, 1);
        ack();

        // 6: reset during WAIT aborts immediately
        mode = 2'd2;
        req_valid = 1'b1; req_op = FPU_ADD; req_a = F1; req_b = F2; req_tag = 4'd1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("t6_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_rst_req_ready", req_ready, 1'b1);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_rsp_valid", rsp_valid, 1'b0);
        check("t6_rst_valid_in", fpu_valid_in, 1'b0);
        check("t6_rst_fpu_a", fpu_a, 64'd0);
        check("t6_rst_trap", rsp_trap, TRAP_NONE);
        check("t6_rst_tag", rsp_tag, 4'd0);
        tick();
        rst = 1'b0;
        mode = 2'd0;
        tick();

        // 6b: statistics over ADD, DIV 0/0 (NaN, 2 stall cycles), LT
        run(FPU_ADD, F1, F2, 4'd1, lat, hb);
        ack();
        run(FPU_DIV, 64'd0, 64'd0, 4'd2, lat, hb);
        check("t6_div_data", rsp_data, QNAN);
        check("t6_div_trap", rsp_trap, TRAP_INT_DIV_ZERO);
        tick();
        tick();
        ack();
        run(FPU_LT, F2, F1, 4'd3, lat, hb);
        check("t6_lt_data", rsp_data, 64'd0);
        ack();
`ifdef WASM_FPU_ISSUE_STATS_EN
        check("t6_stat_issued", stat_issued, 32'd3);
        check("t6_stat_nan", stat_nan, 32'd1);
        check("t6_stat_stall", stat_stall, 32'd2);
`else
        check("t6_stat_issued_off", stat_issued, 32'd0);
        check("t6_stat_nan_off", stat_nan, 32'd0);
        check("t6_stat_stall_off", stat_stall, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule
